// File: rtl/tilemap_sr_pkg.sv
// Shared types and defaults for the tilemap shift-register array.
// Holds the lane mode encoding and a constant clog2 helper.
package tilemap_sr_pkg;

    typedef enum logic [1:0] {
        HOLD = 2'b00,
        SHR  = 2'b01,
        SHL  = 2'b10,
        LOAD = 2'b11
    } mode_e;

    localparam int DEF_BPP   = 4;
    localparam int DEF_TILEW = 8;
    localparam int DLY_W     = 3;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/tilemap_sr_lane.sv
// One tilemap channel: row latch, pixel shifter, shift counter
// with sticky underrun, and a fixed-length output delay line.
module tilemap_sr_lane
    import tilemap_sr_pkg::*;
#(
    parameter int BPP   = DEF_BPP,
    parameter int TILEW = DEF_TILEW,
    parameter int DLY   = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cen_n,
    input  logic [TILEW*BPP-1:0]   gfx,
    input  logic                   latch,
    input  mode_e                  mode,
    input  logic                   flip,
    input  logic                   urun_clr,
    output logic [BPP-1:0]         pixel,
    output logic                   urun
);

    localparam int CW = clog2(TILEW + 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(TILEW);

    logic [TILEW*BPP-1:0]        line_q, line_d;
    logic [TILEW-1:0][BPP-1:0]   px_q, px_d;
    logic [BPP-1:0]              s0_q, s0_d;
    logic [CW-1:0]               cnt_q, cnt_d;
    logic                        urun_q, urun_d;

    always_comb begin
        line_d = line_q;
        px_d   = px_q;
        s0_d   = s0_q;
        cnt_d  = cnt_q;
        urun_d = urun_q;
        if (latch) line_d = gfx;
        if (urun_clr) urun_d = 1'b0;
        unique case (mode)
            HOLD: ;
            LOAD: begin
                // pixel 0 sits in the MSBs of the latched row
                for (int i = 0; i < TILEW; i++) begin
                    px_d[i] = line_q[(TILEW-1-i)*BPP +: BPP];
                end
                cnt_d = '0;
            end
            SHL, SHR: begin
                if ((mode == SHL) == flip) begin
                    s0_d = '0;
                end else if (cnt_q == CNT_FULL) begin
                    s0_d   = '0;
                    urun_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (mode == SHL) begin
                        s0_d = px_q[0];
                        for (int i = 0; i < TILEW - 1; i++) begin
                            px_d[i] = px_q[i+1];
                        end
                        px_d[TILEW-1] = '0;
                    end else begin
                        s0_d = px_q[TILEW-1];
                        for (int i = 1; i < TILEW; i++) begin
                            px_d[i] = px_q[i-1];
                        end
                        px_d[0] = '0;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            line_q <= '0;
            px_q   <= '0;
            s0_q   <= '0;
            cnt_q  <= CNT_FULL;
            urun_q <= 1'b0;
        end else if (!cen_n) begin
            line_q <= line_d;
            px_q   <= px_d;
            s0_q   <= s0_d;
            cnt_q  <= cnt_d;
            urun_q <= urun_d;
        end
    end

    assign urun = urun_q;

    generate
        if (DLY == 0) begin : g_nodly
            assign pixel = s0_q;
        end else begin : g_dly
            logic [BPP-1:0] dly_q [DLY];
            logic [BPP-1:0] dly_d [DLY];

            always_comb begin
                dly_d[0] = s0_q;
                for (int k = 1; k < DLY; k++) begin
                    dly_d[k] = dly_q[k-1];
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int k = 0; k < DLY; k++) begin
                        dly_q[k] <= '0;
                    end
                end else if (!cen_n) begin
                    dly_q <= dly_d;
                end
            end

            assign pixel = dly_q[DLY-1];
        end
    endgenerate

endmodule

// File: rtl/tilemap_sr_array.sv
// NCH independent tilemap shifter lanes with per-lane output delay.
// Define TILEMAP_SR_PRIORITY_EN to add the lowest-index opaque mixer.
module tilemap_sr_array
    import tilemap_sr_pkg::*;
#(
    parameter int NCH   = 2,
    parameter int BPP   = DEF_BPP,
    parameter int TILEW = DEF_TILEW,
    parameter logic [NCH*DLY_W-1:0] OUT_DLY = {3'd0, 3'd3}
) (
    input  logic                    i_EMU_MCLK,
    input  logic                    i_EMU_RST,
    input  logic                    i_EMU_CLK6MPCEN_n,
    input  logic [TILEW*BPP-1:0]    i_GFXDATA,
    input  logic [NCH-1:0]          i_LATCH,
    input  logic [2*NCH-1:0]        i_MODE,
    input  logic [NCH-1:0]          i_FLIP,
    input  logic [NCH-1:0]          i_UNDERRUN_CLR,
    output logic [BPP*NCH-1:0]      o_PIXEL,
    output logic [NCH-1:0]          o_TRN_n,
`ifdef TILEMAP_SR_PRIORITY_EN
    output logic [BPP-1:0]          o_MIX_PIXEL,
    output logic [((NCH > 1) ? clog2(NCH) : 1)-1:0] o_MIX_CH,
    output logic                    o_MIX_TRN_n,
`endif
    output logic [NCH-1:0]          o_UNDERRUN
);

    // delay field 0 is the leftmost field of OUT_DLY
    for (genvar c = 0; c < NCH; c++) begin : g_lane
        tilemap_sr_lane #(
            .BPP   (BPP),
            .TILEW (TILEW),
            .DLY   (int'(OUT_DLY[(NCH-1-c)*DLY_W +: DLY_W]))
        ) u_lane (
            .clk      (i_EMU_MCLK),
            .rst      (i_EMU_RST),
            .cen_n    (i_EMU_CLK6MPCEN_n),
            .gfx      (i_GFXDATA),
            .latch    (i_LATCH[c]),
            .mode     (mode_e'(i_MODE[2*c +: 2])),
            .flip     (i_FLIP[c]),
            .urun_clr (i_UNDERRUN_CLR[c]),
            .pixel    (o_PIXEL[c*BPP +: BPP]),
            .urun     (o_UNDERRUN[c])
        );

        assign o_TRN_n[c] = |o_PIXEL[c*BPP +: BPP];
    end

`ifdef TILEMAP_SR_PRIORITY_EN
    localparam int CH_W = (NCH > 1) ? clog2(NCH) : 1;

    always_comb begin
        o_MIX_PIXEL = '0;
        o_MIX_CH    = '0;
        o_MIX_TRN_n = 1'b0;
        for (int c = NCH - 1; c >= 0; c--) begin
            if (o_TRN_n[c]) begin
                o_MIX_PIXEL = o_PIXEL[c*BPP +: BPP];
                o_MIX_CH    = CH_W'(c);
                o_MIX_TRN_n = 1'b1;
            end
        end
    end
`endif

endmodule
